// File: rtl/heater_delay_array_if.sv
// Control and status bundle for heater_delay_array.
// The master side drives the stall, clear and inject controls and watches the
// per-channel status. The slave side is the datapath array itself.
interface heater_delay_array_if #(
  parameter int CHANNELS  = 4,
  parameter int ERR_CNT_W = 16,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                          enable;
  logic                          err_clear;
  logic                          inject;
  logic [CH_W-1:0]               inject_ch;
  logic [CHANNELS-1:0]           locked;
  logic [CHANNELS-1:0]           error;
  logic [CHANNELS*ERR_CNT_W-1:0] err_count;

  modport master (
    output enable, err_clear, inject, inject_ch,
    input  locked, error, err_count
  );

  modport slave (
    input  enable, err_clear, inject, inject_ch,
    output locked, error, err_count
  );
endinterface

// File: rtl/heater_delay_array.sv
// Multi-channel fabric heater.
// Each lane is a Galois LFSR feeding a BRAM circular delay line, a short
// register pipeline and a checker that locks onto the LFSR sequence by itself.
// Each lane reports its lock state, a sticky error flag and a saturating
// mismatch count. All state advances only while enable is high.
module heater_delay_array #(
  parameter int              CHANNELS    = 4,
  parameter int              DATA_W      = 32,
  parameter logic [DATA_W-1:0] POLY      = 32'h80200003,
  parameter int              DEPTH       = 1024,
  parameter int              PIPE_STAGES = 2,
  parameter int              ERR_CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  heater_delay_array_if.slave bus
);

  localparam int LAT  = DEPTH + 1 + PIPE_STAGES;
  localparam int AW   = $clog2(DEPTH);
  localparam int FW   = $clog2(LAT + 1);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, PRIME, CHECK} state_t;

  // One LFSR step. The generator and the checker share this rule.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : {DATA_W{1'b0}});
  endfunction

  logic [AW-1:0]       wptr_reg;
  logic [CHANNELS-1:0] locked_vec;
  logic [CHANNELS-1:0] error_vec;
  logic [CHANNELS*ERR_CNT_W-1:0] count_vec;

  // All lanes write in lockstep, so they share one write pointer.
  // DEPTH is a power of 2, so the pointer wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg <= '0;
    end else if (bus.enable) begin
      wptr_reg <= wptr_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DATA_W-1:0]    lfsr_reg;
      logic                 inj_hit;
      logic [DATA_W-1:0]    wr_word;
      logic [DATA_W-1:0]    mem [DEPTH];
      logic [DATA_W-1:0]    rd_reg;
      logic [DATA_W-1:0]    pipe_reg [PIPE_STAGES];
      logic [DATA_W-1:0]    chk_in;
      state_t               state_reg, state_next;
      logic [FW-1:0]        fill_reg, fill_next;
      logic [DATA_W-1:0]    prev_reg, prev_next;
      logic                 locked_reg, locked_next;
      logic                 err_reg, err_next;
      logic [ERR_CNT_W-1:0] cnt_reg, cnt_next;
      logic                 mismatch;

      // A target of CHANNELS or higher matches no lane, so that inject is dropped.
      assign inj_hit = bus.inject && (bus.inject_ch == CH_W'(gi));
      // The injected fault is applied only to the stored word. The generator keeps running cleanly.
      assign wr_word = lfsr_reg ^ {{(DATA_W-1){1'b0}}, inj_hit};
      assign chk_in  = pipe_reg[PIPE_STAGES-1];

      // Free-running generator. The seed differs in each lane.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lfsr_reg <= {DATA_W{1'b1}} ^ DATA_W'(gi);
        end else if (bus.enable) begin
          lfsr_reg <= lfsr_step(lfsr_reg);
        end
      end

      // Read-first circular buffer with a registered read. It has no reset, so it maps to block RAM.
      always_ff @(posedge clk) begin
        if (bus.enable) begin
          rd_reg <= mem[wptr_reg];
          mem[wptr_reg] <= wr_word;
        end
      end

      // Register stages between the buffer output and the checker.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_STAGES; i++) pipe_reg[i] <= '0;
        end else if (bus.enable) begin
          pipe_reg[0] <= rd_reg;
          for (int i = 1; i < PIPE_STAGES; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end

      // Checker state register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg  <= IDLE;
          fill_reg   <= '0;
          prev_reg   <= '0;
          locked_reg <= 1'b0;
          err_reg    <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          state_reg  <= state_next;
          fill_reg   <= fill_next;
          prev_reg   <= prev_next;
          locked_reg <= locked_next;
          err_reg    <= err_next;
          cnt_reg    <= cnt_next;
        end
      end

      // Checker next state. It waits out the pipeline fill, takes one word as the seed, then
      // compares each word with the step of the previous one. err_clear overrides any new mismatch.
      always_comb begin
        state_next  = state_reg;
        fill_next   = fill_reg;
        prev_next   = prev_reg;
        locked_next = locked_reg;
        err_next    = err_reg;
        cnt_next    = cnt_reg;
        mismatch    = 1'b0;
        if (bus.enable) begin
          case (state_reg)
            IDLE: begin
              state_next = FILL;
              fill_next  = '0;
            end
            FILL: begin
              fill_next = fill_reg + 1'b1;
              if (fill_reg == FW'(LAT - 1)) state_next = PRIME;
            end
            PRIME: begin
              prev_next   = chk_in;
              locked_next = 1'b1;
              state_next  = CHECK;
            end
            CHECK: begin
              mismatch    = (chk_in != lfsr_step(prev_reg));
              locked_next = !mismatch;
              prev_next   = chk_in;
              if (mismatch) begin
                err_next = 1'b1;
                if (cnt_reg != {ERR_CNT_W{1'b1}}) cnt_next = cnt_reg + 1'b1;
              end
            end
            default: state_next = IDLE;
          endcase
        end
        if (bus.err_clear) begin
          err_next = 1'b0;
          cnt_next = '0;
        end
      end

      assign locked_vec[gi] = locked_reg;
      assign error_vec[gi]  = err_reg;
      assign count_vec[gi*ERR_CNT_W +: ERR_CNT_W] = cnt_reg;
    end
  endgenerate

  assign bus.locked    = locked_vec;
  assign bus.error     = error_vec;
  assign bus.err_count = count_vec;

endmodule

// File: tb/tb_heater_delay_array.sv
// Bench for heater_delay_array.
// Two arrays share every input. One has a 2-bit error counter and the other a
// 16-bit counter, so saturation can be seen next to the true count. A model
// built from the stream rules predicts every output after each clock.
module tb_heater_delay_array;
  localparam int CH    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PS    = 2;
  localparam int LAT   = DEPTH + 1 + PS;
  localparam logic [DW-1:0] POLY = 32'h80200003;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  heater_delay_array_if #(.CHANNELS(CH), .ERR_CNT_W(2))  ifa();
  heater_delay_array_if #(.CHANNELS(CH), .ERR_CNT_W(16)) ifb();

  assign ifb.enable    = ifa.enable;
  assign ifb.err_clear = ifa.err_clear;
  assign ifb.inject    = ifa.inject;
  assign ifb.inject_ch = ifa.inject_ch;

  heater_delay_array #(.CHANNELS(CH), .DATA_W(DW), .POLY(POLY), .DEPTH(DEPTH),
                       .PIPE_STAGES(PS), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  heater_delay_array #(.CHANNELS(CH), .DATA_W(DW), .POLY(POLY), .DEPTH(DEPTH),
                       .PIPE_STAGES(PS), .ERR_CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  // Reference model. Each generated word is stored by its advance index, and
  // the checker receives the word from LAT advances earlier.
  logic [DW-1:0] lfsr_m [CH];
  logic [DW-1:0] hist   [CH][64];
  logic [DW-1:0] prev_m [CH];
  int            cnt_m  [CH];
  logic [CH-1:0] lk_m, err_m;
  int            adv;
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] f(input logic [DW-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  task automatic model_reset();
    adv = 0;
    lk_m = '0;
    err_m = '0;
    for (int c = 0; c < CH; c++) begin
      lfsr_m[c] = 32'hFFFF_FFFF ^ DW'(c);
      cnt_m[c] = 0;
      prev_m[c] = '0;
    end
  endtask

  task automatic model_edge(input logic en, input logic inj, input logic [1:0] ch, input logic clr);
    logic [DW-1:0] r;
    if (en) begin
      for (int c = 0; c < CH; c++) begin
        hist[c][adv % 64] = lfsr_m[c] ^ ((inj && int'(ch) == c) ? 32'h1 : 32'h0);
        lfsr_m[c] = f(lfsr_m[c]);
        if (adv == LAT + 1) begin
          prev_m[c] = hist[c][(adv - LAT) % 64];
          lk_m[c] = 1'b1;
        end else if (adv > LAT + 1) begin
          r = hist[c][(adv - LAT) % 64];
          if (r != f(prev_m[c])) begin
            cnt_m[c]++;
            err_m[c] = 1'b1;
            lk_m[c] = 1'b0;
          end else begin
            lk_m[c] = 1'b1;
          end
          prev_m[c] = r;
        end
      end
      adv++;
    end
    if (clr) begin
      err_m = '0;
      for (int c = 0; c < CH; c++) cnt_m[c] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_lockA"}, 32'(ifa.locked), 32'(lk_m));
    chk({tag, "_errA"},  32'(ifa.error),  32'(err_m));
    chk({tag, "_lockB"}, 32'(ifb.locked), 32'(lk_m));
    chk({tag, "_errB"},  32'(ifb.error),  32'(err_m));
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_cntA%0d", tag, c), 32'(ifa.err_count[c*2 +: 2]),
          32'((cnt_m[c] > 3) ? 3 : cnt_m[c]));
      chk($sformatf("%s_cntB%0d", tag, c), 32'(ifb.err_count[c*16 +: 16]),
          32'((cnt_m[c] > 65535) ? 65535 : cnt_m[c]));
    end
  endtask

  // One clock: drive the inputs, let the edge happen, update the model, then compare just after the edge.
  task automatic cycle(input logic en, input logic inj, input logic [1:0] ch, input logic clr,
                       input string tag);
    ifa.enable = en;
    ifa.inject = inj;
    ifa.inject_ch = ch;
    ifa.err_clear = clr;
    @(posedge clk);
    model_edge(en, inj, ch, clr);
    #1;
    check_all(tag);
  endtask

  int low_cnt;
  int en_edges;
  logic en_r;

  initial begin
    reset = 1'b1;
    ifa.enable = 1'b0;
    ifa.err_clear = 1'b0;
    ifa.inject = 1'b0;
    ifa.inject_ch = '0;
    model_reset();
    #12;
    check_all("reset");
    $display("step reset: outputs checked while reset is held");
    #1 reset = 1'b0;

    // Continuous enable: lock on the 21st advance, then a long clean run.
    repeat (20) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t1");
    chk("t1_lock20", 32'(ifa.locked), 32'h0);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, "t1");
    chk("t1_lock21", 32'(ifa.locked), 32'hF);
    repeat (1979) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t1");
    chk("t1_err", 32'(ifa.error), 32'h0);
    chk("t1_cnt", 32'(ifb.err_count), 32'h0);
    $display("step t1: continuous enable, lock and clean run");

    // Single injection on channel 2.
    cycle(1'b1, 1'b1, 2'd2, 1'b0, "t2");
    low_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b0, 2'd0, 1'b0, "t2");
      if (!ifa.locked[2]) low_cnt++;
    end
    chk("t2_lowcycles", 32'(low_cnt), 32'd2);
    chk("t2_cnt2", 32'(ifb.err_count[2*16 +: 16]), 32'd2);
    chk("t2_error", 32'(ifa.error), 32'h4);
    chk("t2_locked", 32'(ifa.locked), 32'hF);
    $display("step t2: inject ch2, two mismatches then relock");

    // Injection on channel 1, with a clear on the same edge as the second mismatch.
    cycle(1'b1, 1'b0, 2'd0, 1'b1, "t3");
    cycle(1'b1, 1'b1, 2'd1, 1'b0, "t3");
    repeat (LAT - 1) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t3");
    cycle(1'b1, 1'b0, 2'd0, 1'b0, "t3");
    chk("t3_first", 32'(ifb.err_count[1*16 +: 16]), 32'd1);
    cycle(1'b1, 1'b0, 2'd0, 1'b1, "t3");
    chk("t3_clr_cnt", 32'(ifb.err_count[1*16 +: 16]), 32'd0);
    chk("t3_clr_err", 32'(ifa.error[1]), 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, "t3");
    chk("t3_after_cnt", 32'(ifb.err_count[1*16 +: 16]), 32'd0);
    chk("t3_after_err", 32'(ifa.error), 32'd0);
    $display("step t3: clear coincident with second mismatch");

    // Random stall pattern from a fresh reset.
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    en_edges = 0;
    for (int i = 0; i < 5000; i++) begin
      en_r = 1'($urandom % 2);
      cycle(en_r, 1'b0, 2'd0, 1'b0, "t4");
      if (en_r) begin
        en_edges++;
        if (en_edges == 20) chk("t4_lock20", 32'(ifa.locked), 32'h0);
        if (en_edges == 21) chk("t4_lock21", 32'(ifa.locked), 32'hF);
      end
    end
    chk("t4_err", 32'(ifa.error), 32'h0);
    chk("t4_cnt", 32'(ifb.err_count), 32'h0);
    $display("step t4: random enable, %0d enabled edges", en_edges);

    // Three injections on channel 0, spaced 40 advances apart.
    cycle(1'b1, 1'b0, 2'd0, 1'b1, "t5");
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 2'd0, 1'b0, "t5");
      repeat (39) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t5");
    end
    repeat (40) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t5");
    chk("t5_satA", 32'(ifa.err_count[1:0]), 32'd3);
    chk("t5_fullB", 32'(ifb.err_count[15:0]), 32'd6);
    chk("t5_err0", 32'(ifa.error[0]), 32'd1);
    $display("step t5: saturating counter on ch0");

    // Asynchronous reset pulse between clock edges.
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("t6_async");
    chk("t6_cntA", 32'(ifa.err_count), 32'h0);
    #1 reset = 1'b0;
    repeat (20) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t6");
    chk("t6_lock20", 32'(ifa.locked), 32'h0);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, "t6");
    chk("t6_lock21", 32'(ifa.locked), 32'hF);
    repeat (100) cycle(1'b1, 1'b0, 2'd0, 1'b0, "t6");
    chk("t6_err", 32'(ifa.error), 32'h0);
    $display("step t6: async reset mid-check and relock");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
